// File: rtl/ram_sdp_clear.sv
`default_nettype none
// ============================================================================
// Module   : ram_sdp_clear
// Purpose  : Single-clock simple-dual-port RAM with per-byte write enables,
//            selectable read-during-write policy, optional output register
//            and a hardware clear engine that fills every word with
//            CLEAR_VALUE after reset or on request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   Clock          in   1              rising-edge clock for all logic
//   Reset          in   1              asynchronous active-high reset
//   Clear_i        in   1              request a full clear (sampled in READY)
//   Busy_o         out  1              high while the clear engine owns memory
//   WriteEnable_i  in   1              write strobe
//   ByteEnable_i   in   LANES          per-lane write mask
//   WriteAddress_i in   ADDRESS_WIDTH  write address
//   Data_i         in   DATA_WIDTH     write data
//   ReadEnable_i   in   1              read strobe
//   ReadAddress_i  in   ADDRESS_WIDTH  read address
//   Data_o         out  DATA_WIDTH     read data (holds between reads)
//   DataValid_o    out  1              one-cycle pulse per returned word
// ============================================================================
module ram_sdp_clear #(
    parameter int                    ADDRESS_WIDTH = 4,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    BYTE_WIDTH    = 8,
    parameter int                    RDW_MODE      = 0,
    parameter int                    OUTPUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               Clear_i,
    output logic                               Busy_o,
    input  logic                               WriteEnable_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   ByteEnable_i,
    input  logic [ADDRESS_WIDTH-1:0]           WriteAddress_i,
    input  logic [DATA_WIDTH-1:0]              Data_i,
    input  logic                               ReadEnable_i,
    input  logic [ADDRESS_WIDTH-1:0]           ReadAddress_i,
    output logic [DATA_WIDTH-1:0]              Data_o,
    output logic                               DataValid_o
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

    // ------------------------------------------------------------------
    // Clear engine FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [ADDRESS_WIDTH-1:0]   clear_addr;
    logic [ADDRESS_WIDTH-1:0]   clear_addr_next;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_CLEAR;
            clear_addr <= '0;
        end else begin
            state      <= state_next;
            clear_addr <= clear_addr_next;
        end
    end

    always_comb begin
        state_next      = state;
        clear_addr_next = clear_addr;
        case (state)
            S_CLEAR: begin
                // The counter wraps naturally to 0 after the last word.
                clear_addr_next = clear_addr + 1'b1;
                if (clear_addr == '1) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                if (Clear_i) begin
                    state_next      = S_CLEAR;
                    clear_addr_next = '0;
                end
            end
            default: begin
                state_next      = S_CLEAR;
                clear_addr_next = '0;
            end
        endcase
    end

    logic ready;
    assign ready  = (state == S_READY);
    assign Busy_o = ~ready;

    // User accesses are only honoured once the clear engine has finished.
    logic user_write;
    logic user_read;
    assign user_write = ready & WriteEnable_i;
    assign user_read  = ready & ReadEnable_i;

    // ------------------------------------------------------------------
    // Write port mux: clear engine or user
    // ------------------------------------------------------------------
    logic                       mem_we;
    logic [LANES-1:0]           mem_be;
    logic [ADDRESS_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]      mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_waddr = WriteAddress_i;
        mem_wdata = Data_i;
        if (!ready) begin
            // Reset holds the FSM in CLEAR; the array itself must not be
            // written until reset is released.
            mem_we    = ~Reset;
            mem_be    = '1;
            mem_waddr = clear_addr;
            mem_wdata = CLEAR_VALUE;
        end else if (user_write) begin
            mem_we    = 1'b1;
            mem_be    = ByteEnable_i;
        end
    end

    // ------------------------------------------------------------------
    // Storage array (no reset: contents only change through the write port)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            for (int k = 0; k < LANES; k++) begin
                if (mem_be[k]) begin
                    mem[mem_waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path. The array read sees pre-write contents because the write
    // lands on the same edge; new-data mode merges the enabled write lanes
    // in front of the read register rather than re-reading the array.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rdw_hit;

    assign rdw_hit = (RDW_MODE != 0) && user_write && (WriteAddress_i == ReadAddress_i);

    always_comb begin
        rd_word = mem[ReadAddress_i];
        if (rdw_hit) begin
            for (int k = 0; k < LANES; k++) begin
                if (ByteEnable_i[k]) begin
                    rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = Data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= user_read;
            if (user_read) begin
                rd_data <= rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output stage. Data only advances with a valid word so the
    // output holds its last value between reads.
    // ------------------------------------------------------------------
    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_data;
            logic                  out_valid;

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    out_data  <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= rd_valid;
                    if (rd_valid) begin
                        out_data <= rd_data;
                    end
                end
            end

            assign Data_o      = out_data;
            assign DataValid_o = out_valid;
        end else begin : g_out_direct
            assign Data_o      = rd_data;
            assign DataValid_o = rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_clear.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sdp_clear
// Purpose  : Directed self-checking bench. Two instances share the stimulus:
//            dut0 = old-data RDW, latency 1; dut1 = new-data RDW, latency 2.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_sdp_clear;

    localparam logic [15:0] CV = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        we  = 1'b0;
    logic        re  = 1'b0;
    logic [1:0]  be  = '0;
    logic [3:0]  wa  = '0;
    logic [3:0]  ra  = '0;
    logic [15:0] wd  = '0;

    logic [15:0] d0, d1;
    logic        v0, v1, b0, b1;

    int vectors     = 0;
    int miscompares = 0;

    // Expected memory image plus per-instance output expectations.
    logic [15:0] model [16];
    logic [15:0] last0, last1, pend1;
    logic        pend1_v;

    always #5 clk = ~clk;

    ram_sdp_clear #(
        .ADDRESS_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8),
        .RDW_MODE(0), .OUTPUT_REG(0), .CLEAR_VALUE(CV)
    ) dut0 (
        .Clock(clk), .Reset(rst), .Clear_i(clr), .Busy_o(b0),
        .WriteEnable_i(we), .ByteEnable_i(be), .WriteAddress_i(wa), .Data_i(wd),
        .ReadEnable_i(re), .ReadAddress_i(ra), .Data_o(d0), .DataValid_o(v0)
    );

    ram_sdp_clear #(
        .ADDRESS_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8),
        .RDW_MODE(1), .OUTPUT_REG(1), .CLEAR_VALUE(CV)
    ) dut1 (
        .Clock(clk), .Reset(rst), .Clear_i(clr), .Busy_o(b1),
        .WriteEnable_i(we), .ByteEnable_i(be), .WriteAddress_i(wa), .Data_i(wd),
        .ReadEnable_i(re), .ReadAddress_i(ra), .Data_o(d1), .DataValid_o(v1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One READY-state cycle: drive, advance one edge, check both outputs.
    task automatic op(input logic w, input logic [1:0] m, input logic [3:0] aw,
                      input logic [15:0] dw, input logic r, input logic [3:0] ar);
        logic [15:0] e_old;
        logic [15:0] e_new;
        e_old = model[ar];
        e_new = e_old;
        if (w && aw == ar) begin
            for (int k = 0; k < 2; k++)
                if (m[k]) e_new[k*8 +: 8] = dw[k*8 +: 8];
        end
        if (w) begin
            for (int k = 0; k < 2; k++)
                if (m[k]) model[aw][k*8 +: 8] = dw[k*8 +: 8];
        end
        we = w; be = m; wa = aw; wd = dw; re = r; ra = ar;
        step();
        we = 1'b0; re = 1'b0;
        if (r) begin
            chk("rd_data0", d0, e_old);
            chk("rd_valid0", v0, 1'b1);
            last0 = e_old;
        end else begin
            chk("idle_valid0", v0, 1'b0);
            chk("hold_data0", d0, last0);
        end
        if (pend1_v) begin
            chk("rd_data1", d1, pend1);
            chk("rd_valid1", v1, 1'b1);
            last1 = pend1;
        end else begin
            chk("idle_valid1", v1, 1'b0);
            chk("hold_data1", d1, last1);
        end
        pend1_v = r;
        pend1   = e_new;
    endtask

    // Counts edges until Busy_o falls on each instance (bounded).
    task automatic wait_clear(input string tag);
        int f0;
        int f1;
        f0 = 0;
        f1 = 0;
        for (int n = 1; n <= 40 && (f0 == 0 || f1 == 0); n++) begin
            step();
            if (f0 == 0 && !b0) f0 = n;
            if (f1 == 0 && !b1) f1 = n;
        end
        chk({tag, "_busy_len0"}, 16'(f0), 16'd16);
        chk({tag, "_busy_len1"}, 16'(f1), 16'd16);
        for (int i = 0; i < 16; i++) model[i] = CV;
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) op(1'b0, 2'b00, 4'd0, 16'd0, 1'b1, 4'(i));
        op(1'b0, 2'b00, 4'd0, 16'd0, 1'b0, 4'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy0"},  b0, 1'b1);
        chk({tag, "_data0"},  d0, 16'h0000);
        chk({tag, "_valid0"}, v0, 1'b0);
        chk({tag, "_busy1"},  b1, 1'b1);
        chk({tag, "_data1"},  d1, 16'h0000);
        chk({tag, "_valid1"}, v1, 1'b0);
        last0   = '0;
        last1   = '0;
        pend1   = '0;
        pend1_v = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        last0 = '0; last1 = '0; pend1 = '0; pend1_v = 1'b0;

        // Power-on reset and first clear
        #2 rst = 1'b1;
        step();
        step();
        check_reset_outputs("por");
        rst = 1'b0;
        wait_clear("por");
        read_all();

        // Byte lanes: 1234 full, then FF00 low lane only -> 1200
        op(1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 4'd0);
        op(1'b1, 2'b01, 4'd3, 16'hFF00, 1'b0, 4'd0);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3);
        chk("lanes_d0", d0, 16'h1200);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
        chk("lanes_d1", d1, 16'h1200);

        // Read during write: 00AA then BBCC high lane with a read of 5
        op(1'b1, 2'b11, 4'd5, 16'h00AA, 1'b0, 4'd0);
        op(1'b1, 2'b10, 4'd5, 16'hBBCC, 1'b1, 4'd5);
        chk("rdw_old_d0", d0, 16'h00AA);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5);
        chk("rdw_new_d1", d1, 16'hBBAA);
        chk("rdw_after_d0", d0, 16'hBBAA);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
        chk("rdw_after_d1", d1, 16'hBBAA);

        // Simultaneous streams: write 0..15 while reading 15..0
        for (int i = 0; i < 16; i++)
            op(1'b1, 2'b11, 4'(i), {4'(i), 4'(15 - i), 8'h3C}, 1'b1, 4'(15 - i));
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);

        // Fill with address, then request a clear
        for (int i = 0; i < 16; i++) op(1'b1, 2'b11, 4'(i), 16'(i), 1'b0, 4'd0);
        clr = 1'b1;
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
        chk("clr_busy0", b0, 1'b1);
        chk("clr_busy1", b1, 1'b1);
        // Junk traffic (and a held Clear_i) while busy must be ignored
        for (int k = 1; k <= 16; k++) begin
            we = 1'b1; re = 1'b1; be = 2'b11; wa = 4'(k); ra = 4'(k); wd = 16'hDEAD;
            step();
            chk("clr_busy_seq0", b0, (k < 16) ? 1'b1 : 1'b0);
            chk("clr_busy_seq1", b1, (k < 16) ? 1'b1 : 1'b0);
            chk("clr_valid0", v0, 1'b0);
            chk("clr_valid1", v1, 1'b0);
            chk("clr_hold0", d0, last0);
            chk("clr_hold1", d1, last1);
        end
        we = 1'b0; re = 1'b0; clr = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = CV;
        read_all();

        // Reset during a clear, at clear address 7
        for (int i = 0; i < 16; i++) op(1'b1, 2'b11, 4'(i), 16'h5550 + 16'(i), 1'b0, 4'd0);
        clr = 1'b1;
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
        clr = 1'b0;
        for (int k = 0; k < 7; k++) step();
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        step();
        step();
        chk("midrst_hold_busy0", b0, 1'b1);
        rst = 1'b0;
        wait_clear("midrst");
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
